// File: rtl/cic_comp_chan_sched_pkg.sv
// Shared constants for the CIC-compensation channel scheduler: default sample
// width, channel count, banked-multiplier latency and the channel-index width.
package cic_comp_chan_sched_pkg;

    localparam int CIC_WIDTH   = 18;
    localparam int CIC_NCH     = 2;
    localparam int CIC_LATENCY = 3;

    // Channel index width; never narrower than one bit so a 1-channel select still exists.
    function automatic int chan_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cic_comp_chan_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester strictly after ptr
// (wrapping modulo NCH) wins, so the last winner has the lowest priority.
module cic_comp_chan_sched_rr_arbiter
    import cic_comp_chan_sched_pkg::*;
#(
    parameter int  NCH = CIC_NCH,
    localparam int CHW = chan_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] gnt_oh,
    output logic [CHW-1:0] gnt_idx,
    output logic           gnt_any
);

    function automatic logic [CHW-1:0] cand_idx(input logic [CHW-1:0] base, input int off);
        return CHW'((int'(base) + off) % NCH);
    endfunction

    // Walk from the farthest candidate to the nearest so the nearest pending one overwrites.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = NCH; i >= 1; i--) begin
            if (req[cand_idx(ptr, i)]) begin
                gnt_oh                   = '0;
                gnt_oh[cand_idx(ptr, i)] = 1'b1;
                gnt_idx                  = cand_idx(ptr, i);
                gnt_any                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cic_comp_chan_sched.sv
// Shares one CIC-compensation datapath between NCH decimated streams: buffers one
// sample per channel, issues round-robin and routes each result back by tag.
module cic_comp_chan_sched
    import cic_comp_chan_sched_pkg::*;
#(
    parameter int  NCH     = CIC_NCH,
    parameter int  WIDTH   = CIC_WIDTH,
    parameter int  LATENCY = CIC_LATENCY,
    localparam int CHW     = chan_w(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 flush,
    input  logic [NCH*WIDTH-1:0] chIn,
    input  logic [NCH-1:0]       chEn,
    output logic [WIDTH-1:0]     mpyIn,
    output logic                 mpyEn,
    output logic [CHW-1:0]       mpyChSel,
    input  logic [WIDTH-1:0]     mpyOut,
    output logic [NCH*WIDTH-1:0] chOut,
    output logic [NCH-1:0]       chOutEn,
    output logic [NCH-1:0]       ovf,
    input  logic                 ovfClr
);

    logic [WIDTH-1:0]   hold_q [NCH];
    logic [WIDTH-1:0]   hold_d [NCH];
    logic [NCH-1:0]     pending_q, pending_d;
    logic [CHW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               mpy_en_q, mpy_en_d;
    logic [WIDTH-1:0]   mpy_in_q, mpy_in_d;
    logic [CHW-1:0]     mpy_sel_q, mpy_sel_d;
    logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [CHW-1:0]     tag_chan_q [LATENCY];
    logic [CHW-1:0]     tag_chan_d [LATENCY];
    logic [WIDTH-1:0]   ch_out_q [NCH];
    logic [WIDTH-1:0]   ch_out_d [NCH];
    logic [NCH-1:0]     ch_out_en_q, ch_out_en_d;
    logic [NCH-1:0]     ovf_q, ovf_d;

    logic [NCH-1:0]     gnt_oh;
    logic [CHW-1:0]     gnt_idx;
    logic               gnt_any;
    logic               grant;
    logic [NCH-1:0]     gnt_mask;
    logic [NCH-1:0]     capture;
    logic [NCH-1:0]     overrun;
    logic               tail_valid;
    logic [CHW-1:0]     tail_chan;

    cic_comp_chan_sched_rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .req     (pending_q),
        .ptr     (rr_ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Issue path; flush suppresses the grant so rrPtr is left where it was.
    always_comb begin
        grant     = enable & gnt_any & ~flush;
        gnt_mask  = grant ? gnt_oh : '0;
        mpy_en_d  = grant;
        mpy_in_d  = mpy_in_q;
        mpy_sel_d = mpy_sel_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant) begin
            mpy_in_d  = hold_q[gnt_idx];
            mpy_sel_d = gnt_idx;
            rr_ptr_d  = gnt_idx;
        end
    end

    assign tail_valid = tag_valid_q[LATENCY-1] & ~flush;
    assign tail_chan  = tag_chan_q[LATENCY-1];

    genvar gi;
    for (gi = 0; gi < NCH; gi++) begin : g_chan
        // A channel being granted at this edge frees its slot, so a new strobe is not an overrun.
        assign overrun[gi]     = chEn[gi] & ~flush & pending_q[gi] & ~gnt_mask[gi];
        assign capture[gi]     = chEn[gi] & ~flush & ~overrun[gi];
        assign hold_d[gi]      = capture[gi] ? chIn[gi*WIDTH +: WIDTH] : hold_q[gi];
        assign pending_d[gi]   = ~flush & (capture[gi] | (pending_q[gi] & ~gnt_mask[gi]));
        assign ovf_d[gi]       = overrun[gi] | (ovf_q[gi] & ~ovfClr);
        assign ch_out_en_d[gi] = tail_valid & (tail_chan == CHW'(gi));
        assign ch_out_d[gi]    = ch_out_en_d[gi] ? mpyOut : ch_out_q[gi];
        assign chOut[gi*WIDTH +: WIDTH] = ch_out_q[gi];
    end

    // Tag shift register mirrors the datapath pipeline one stage behind the issue register.
    assign tag_valid_d[0] = mpy_en_q & ~flush;
    assign tag_chan_d[0]  = mpy_sel_q;
    for (gi = 1; gi < LATENCY; gi++) begin : g_tag
        assign tag_valid_d[gi] = tag_valid_q[gi-1] & ~flush;
        assign tag_chan_d[gi]  = tag_chan_q[gi-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '{default: '0};
            pending_q   <= '0;
            rr_ptr_q    <= CHW'(NCH - 1);
            mpy_en_q    <= 1'b0;
            mpy_in_q    <= '0;
            mpy_sel_q   <= '0;
            tag_valid_q <= '0;
            tag_chan_q  <= '{default: '0};
            ch_out_q    <= '{default: '0};
            ch_out_en_q <= '0;
            ovf_q       <= '0;
        end else begin
            hold_q      <= hold_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            mpy_en_q    <= mpy_en_d;
            mpy_in_q    <= mpy_in_d;
            mpy_sel_q   <= mpy_sel_d;
            tag_valid_q <= tag_valid_d;
            tag_chan_q  <= tag_chan_d;
            ch_out_q    <= ch_out_d;
            ch_out_en_q <= ch_out_en_d;
            ovf_q       <= ovf_d;
        end
    end

    assign mpyIn    = mpy_in_q;
    assign mpyEn    = mpy_en_q;
    assign mpyChSel = mpy_sel_q;
    assign chOutEn  = ch_out_en_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_cic_comp_chan_sched.sv
// Directed bench for the channel scheduler with a stub datapath returning
// mpyIn + 1 + mpyChSel after LATENCY register stages.
module tb_cic_comp_chan_sched;

    localparam int NCH     = 2;
    localparam int WIDTH   = 18;
    localparam int LATENCY = 3;

    logic                 clk     = 1'b0;
    logic                 reset   = 1'b1;
    logic                 enable  = 1'b0;
    logic                 flush   = 1'b0;
    logic                 ovfClr  = 1'b0;
    logic [NCH*WIDTH-1:0] chIn    = '0;
    logic [NCH-1:0]       chEn    = '0;
    logic [WIDTH-1:0]     mpyIn;
    logic                 mpyEn;
    logic [0:0]           mpyChSel;
    logic [WIDTH-1:0]     mpyOut;
    logic [NCH*WIDTH-1:0] chOut;
    logic [NCH-1:0]       chOutEn;
    logic [NCH-1:0]       ovf;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] out_q0 [$];
    logic [WIDTH-1:0] out_q1 [$];
    logic             iss_q  [$];
    int               out_evts = 0;

    logic [WIDTH-1:0] stub_q [LATENCY];

    always #5 clk = ~clk;

    cic_comp_chan_sched #(
        .NCH     (NCH),
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .flush    (flush),
        .chIn     (chIn),
        .chEn     (chEn),
        .mpyIn    (mpyIn),
        .mpyEn    (mpyEn),
        .mpyChSel (mpyChSel),
        .mpyOut   (mpyOut),
        .chOut    (chOut),
        .chOutEn  (chOutEn),
        .ovf      (ovf),
        .ovfClr   (ovfClr)
    );

    always @(posedge clk) begin
        stub_q[0] <= mpyIn + WIDTH'(1) + WIDTH'(mpyChSel);
        for (int s = 1; s < LATENCY; s++) stub_q[s] <= stub_q[s-1];
    end
    assign mpyOut = stub_q[LATENCY-1];

    always @(negedge clk) begin
        if (mpyEn === 1'b1) iss_q.push_back(mpyChSel[0]);
        if (chOutEn[0] === 1'b1) out_q0.push_back(chOut[WIDTH-1:0]);
        if (chOutEn[1] === 1'b1) out_q1.push_back(chOut[2*WIDTH-1:WIDTH]);
        if (chOutEn !== 2'b00) out_evts++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (mpyEn !== 1'b0 || mpyIn !== '0 || mpyChSel !== 1'b0 || chOut !== '0 || chOutEn !== '0 || ovf !== '0) begin
            errors++;
            $display("FAIL reset_state: mpyEn=%b mpyIn=%h sel=%b chOut=%h chOutEn=%b ovf=%b required all zero",
                     mpyEn, mpyIn, mpyChSel, chOut, chOutEn, ovf);
        end
        reset = 1'b0;
        tick(1);
        checks++;
        if (mpyEn !== 1'b0 || chOutEn !== '0) begin
            errors++;
            $display("FAIL reset_idle: mpyEn=%b chOutEn=%b required 0/00", mpyEn, chOutEn);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        chIn[WIDTH-1:0] = 18'h10000;
        chEn = 2'b01;
        tick(1);
        chEn = 2'b00;
        tick(1);
        checks++;
        if (mpyEn !== 1'b1 || mpyIn !== 18'h10000 || mpyChSel !== 1'b0) begin
            errors++;
            $display("FAIL single_issue: mpyEn=%b mpyIn=%h sel=%b required 1/10000/0", mpyEn, mpyIn, mpyChSel);
        end
        for (int k = 2; k <= 4; k++) begin
            tick(1);
            checks++;
            if (chOutEn !== 2'b00 || mpyEn !== 1'b0) begin
                errors++;
                $display("FAIL single_early E+%0d: chOutEn=%b mpyEn=%b required 00/0", k, chOutEn, mpyEn);
            end
        end
        tick(1);
        checks++;
        if (chOutEn !== 2'b01 || chOut[WIDTH-1:0] !== 18'h10001) begin
            errors++;
            $display("FAIL single_result: chOutEn=%b chOut0=%h required 01/10001", chOutEn, chOut[WIDTH-1:0]);
        end
        tick(1);
        checks++;
        if (chOutEn !== 2'b00) begin
            errors++;
            $display("FAIL single_strobe_len: chOutEn=%b required 00", chOutEn);
        end
        $display("test_single done");
    endtask

    task automatic test_simultaneous();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chIn = {18'h00200, 18'h00100};
        chEn = 2'b11;
        tick(1);
        chEn = 2'b00;
        tick(1);
        checks++;
        if (mpyEn !== 1'b1 || mpyIn !== 18'h00100 || mpyChSel !== 1'b0) begin
            errors++;
            $display("FAIL simul_first: mpyEn=%b mpyIn=%h sel=%b required 1/00100/0", mpyEn, mpyIn, mpyChSel);
        end
        tick(1);
        checks++;
        if (mpyEn !== 1'b1 || mpyIn !== 18'h00200 || mpyChSel !== 1'b1) begin
            errors++;
            $display("FAIL simul_second: mpyEn=%b mpyIn=%h sel=%b required 1/00200/1", mpyEn, mpyIn, mpyChSel);
        end
        tick(3);
        checks++;
        if (chOutEn !== 2'b01 || chOut[WIDTH-1:0] !== 18'h00101) begin
            errors++;
            $display("FAIL simul_out0: chOutEn=%b chOut0=%h required 01/00101", chOutEn, chOut[WIDTH-1:0]);
        end
        tick(1);
        checks++;
        if (chOutEn !== 2'b10 || chOut[2*WIDTH-1:WIDTH] !== 18'h00202) begin
            errors++;
            $display("FAIL simul_out1: chOutEn=%b chOut1=%h required 10/00202", chOutEn, chOut[2*WIDTH-1:WIDTH]);
        end
        tick(3);
        $display("test_simultaneous done");
    endtask

    task automatic test_overrun();
        int b1;
        b1 = out_q1.size();
        enable = 1'b0;
        chIn[2*WIDTH-1:WIDTH] = 18'h00AAA;
        chEn = 2'b10;
        tick(1);
        chIn[2*WIDTH-1:WIDTH] = 18'h00BBB;
        tick(1);
        chEn = 2'b00;
        checks++;
        if (ovf !== 2'b10 || mpyEn !== 1'b0) begin
            errors++;
            $display("FAIL ovr_flag: ovf=%b mpyEn=%b required 10/0", ovf, mpyEn);
        end
        enable = 1'b1;
        tick(1);
        checks++;
        if (mpyEn !== 1'b1 || mpyIn !== 18'h00AAA || mpyChSel !== 1'b1) begin
            errors++;
            $display("FAIL ovr_issue: mpyEn=%b mpyIn=%h sel=%b required 1/00AAA/1", mpyEn, mpyIn, mpyChSel);
        end
        tick(1);
        checks++;
        if (mpyEn !== 1'b0) begin
            errors++;
            $display("FAIL ovr_single_issue: mpyEn=%b required 0", mpyEn);
        end
        tick(6);
        checks++;
        if (out_q1.size() != b1 + 1 || out_q1[out_q1.size()-1] !== 18'h00AAC) begin
            errors++;
            $display("FAIL ovr_result: count=%0d last=%h required 1/00AAC", out_q1.size() - b1,
                     out_q1.size() > 0 ? out_q1[out_q1.size()-1] : 18'h0);
        end
        checks++;
        if (ovf !== 2'b10) begin
            errors++;
            $display("FAIL ovr_sticky: ovf=%b required 10", ovf);
        end
        ovfClr = 1'b1;
        tick(1);
        ovfClr = 1'b0;
        checks++;
        if (ovf !== 2'b00) begin
            errors++;
            $display("FAIL ovr_clear: ovf=%b required 00", ovf);
        end
        $display("test_overrun done");
    endtask

    task automatic test_round_robin();
        int b0, b1, bi;
        b0 = out_q0.size();
        b1 = out_q1.size();
        bi = iss_q.size();
        for (int i = 0; i < 64; i++) begin
            chIn = {WIDTH'(32'h20000 + i), WIDTH'(i)};
            chEn = 2'b11;
            tick(1);
            chEn = 2'b00;
            tick(1);
        end
        tick(8);
        checks++;
        if (iss_q.size() - bi != 128) begin
            errors++;
            $display("FAIL rr_issue_count: got %0d required 128", iss_q.size() - bi);
        end
        for (int k = 0; k < 128 && bi + k < iss_q.size(); k++) begin
            checks++;
            if (iss_q[bi+k] !== 1'(k % 2)) begin
                errors++;
                $display("FAIL rr_sel[%0d]: got %b required %0d", k, iss_q[bi+k], k % 2);
            end
        end
        checks++;
        if (out_q0.size() - b0 != 64 || out_q1.size() - b1 != 64) begin
            errors++;
            $display("FAIL rr_out_count: ch0=%0d ch1=%0d required 64/64", out_q0.size() - b0, out_q1.size() - b1);
        end
        for (int i = 0; i < 64 && b0 + i < out_q0.size() && b1 + i < out_q1.size(); i++) begin
            checks++;
            if (out_q0[b0+i] !== WIDTH'(i + 1) || out_q1[b1+i] !== WIDTH'(32'h20000 + i + 2)) begin
                errors++;
                $display("FAIL rr_data[%0d]: ch0=%h ch1=%h required %h/%h", i, out_q0[b0+i], out_q1[b1+i],
                         WIDTH'(i + 1), WIDTH'(32'h20000 + i + 2));
            end
        end
        checks++;
        if (ovf !== 2'b00) begin
            errors++;
            $display("FAIL rr_ovf: ovf=%b required 00", ovf);
        end
        $display("test_round_robin done");
    endtask

    task automatic test_same_edge();
        int b0;
        b0 = out_q0.size();
        enable = 1'b0;
        chIn[WIDTH-1:0] = 18'h00111;
        chEn = 2'b01;
        tick(1);
        enable = 1'b1;
        chIn[WIDTH-1:0] = 18'h00222;
        tick(1);
        chEn = 2'b00;
        checks++;
        if (mpyEn !== 1'b1 || mpyIn !== 18'h00111 || mpyChSel !== 1'b0 || ovf !== 2'b00) begin
            errors++;
            $display("FAIL same_edge_old: mpyEn=%b mpyIn=%h sel=%b ovf=%b required 1/00111/0/00",
                     mpyEn, mpyIn, mpyChSel, ovf);
        end
        tick(1);
        checks++;
        if (mpyEn !== 1'b1 || mpyIn !== 18'h00222 || mpyChSel !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_new: mpyEn=%b mpyIn=%h sel=%b required 1/00222/0", mpyEn, mpyIn, mpyChSel);
        end
        tick(1);
        checks++;
        if (mpyEn !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_idle: mpyEn=%b required 0", mpyEn);
        end
        tick(6);
        checks++;
        if (out_q0.size() != b0 + 2 || out_q0[b0] !== 18'h00112 || out_q0[b0+1] !== 18'h00223) begin
            errors++;
            $display("FAIL same_edge_results: count=%0d required 2 with 00112,00223", out_q0.size() - b0);
        end
        $display("test_same_edge done");
    endtask

    task automatic launch_three();
        chIn = {18'h30002, 18'h30001};
        chEn = 2'b11;
        tick(1);
        chEn = 2'b00;
        tick(1);
        chIn[WIDTH-1:0] = 18'h30003;
        chEn = 2'b01;
        tick(1);
        chEn = 2'b00;
        tick(1);
    endtask

    task automatic test_flush();
        int be, bi;
        launch_three();
        bi = iss_q.size() + 1;
        be = out_evts;
        flush = 1'b1;
        chIn[2*WIDTH-1:WIDTH] = 18'h30004;
        chEn = 2'b10;
        tick(1);
        flush = 1'b0;
        chEn = 2'b00;
        checks++;
        if (mpyEn !== 1'b0 || chOutEn !== 2'b00) begin
            errors++;
            $display("FAIL flush_edge: mpyEn=%b chOutEn=%b required 0/00", mpyEn, chOutEn);
        end
        tick(8);
        checks++;
        if (out_evts != be || iss_q.size() != bi) begin
            errors++;
            $display("FAIL flush_quiet: new outputs=%0d new issues=%0d required 0/0", out_evts - be, iss_q.size() - bi);
        end
        checks++;
        if (chOut !== {18'h20041, 18'h00223}) begin
            errors++;
            $display("FAIL flush_chout: chOut=%h required %h", chOut, {18'h20041, 18'h00223});
        end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        int be, bi;
        launch_three();
        reset = 1'b1;
        #1;
        checks++;
        if (mpyEn !== 1'b0 || chOut !== '0 || chOutEn !== '0 || ovf !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: mpyEn=%b chOut=%h chOutEn=%b ovf=%b required all zero",
                     mpyEn, chOut, chOutEn, ovf);
        end
        tick(1);
        reset = 1'b0;
        be = out_evts;
        bi = iss_q.size();
        tick(8);
        checks++;
        if (out_evts != be || iss_q.size() != bi || mpyEn !== 1'b0 || chOut !== '0) begin
            errors++;
            $display("FAIL reset_mid_quiet: outputs=%0d issues=%0d mpyEn=%b chOut=%h required 0/0/0/0",
                     out_evts - be, iss_q.size() - bi, mpyEn, chOut);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        enable = 1'b1;
        test_single();
        test_simultaneous();
        test_overrun();
        test_round_robin();
        test_same_edge();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
